// File: rtl/kangaroo_pkg.sv
// Shared definitions for the pixel serializer path.
// Holds default geometry and the universal shift-register mode encoding,
// which follows the LS299 S1/S0 select pins (00 hold, 01 right, 10 left, 11 load).
package kangaroo_pkg;

  localparam int unsigned PIX_WIDTH  = 8;
  localparam int unsigned PIX_PLANES = 2;

  typedef enum logic [1:0] {
    SR_HOLD = 2'b00,
    SR_SHR  = 2'b01,
    SR_SHL  = 2'b10,
    SR_LOAD = 2'b11
  } sr_mode_t;

  // Map pixel enable / load strobe / flip into a shift-register mode.
  function automatic sr_mode_t sr_mode_decode(input logic en, input logic ld,
                                              input logic flip);
    sr_mode_t m;
    m = SR_HOLD;
    if (ld)        m = SR_LOAD;
    else if (en)   m = flip ? SR_SHR : SR_SHL;
    return m;
  endfunction

endpackage

// File: rtl/ls299.sv
// Universal shift register modelled on the 74LS299.
// Ports:
//   CLK   - clock, all updates on rising edge
//   _CLR  - asynchronous active-low clear
//   mode  - hold / shift right / shift left / parallel load
//   sin_r - serial bit entering at the MSB on a right shift
//   sin_l - serial bit entering at the LSB on a left shift
//   din   - parallel load data
//   q     - register contents
module ls299
  import kangaroo_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             _CLR,
  input  sr_mode_t         mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  // Mode-selected register update.
  always_ff @(posedge CLK or negedge _CLR) begin
    if (!_CLR) begin
      q <= '0;
    end else begin
      case (mode)
        SR_SHR:  q <= {sin_r, q[WIDTH-1:1]};
        SR_SHL:  q <= {q[WIDTH-2:0], sin_l};
        SR_LOAD: q <= din;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/pixel_shifter.sv
// Video pixel serializer: loads one byte per bitplane and shifts one pixel
// out per enabled clock. FLIP selects LSB-first output to undo a screen flip.
// Ports:
//   CLK    - clock
//   _CLR   - asynchronous active-low clear
//   PIX_EN - pixel clock enable
//   SYNC   - line-start alignment, forces a load on the next enabled edge
//   FLIP   - 0 MSB-first (shift left), 1 LSB-first (shift right)
//   D      - plane bytes, plane p at D[p*WIDTH +: WIDTH]
//   PIX    - current pixel, bit p from plane p (combinational select)
//   LD     - fetch strobe, high when the current enabled edge loads D
module pixel_shifter
  import kangaroo_pkg::*;
#(
  parameter int unsigned WIDTH  = PIX_WIDTH,
  parameter int unsigned PLANES = PIX_PLANES
) (
  input  logic                    CLK,
  input  logic                    _CLR,
  input  logic                    PIX_EN,
  input  logic                    SYNC,
  input  logic                    FLIP,
  input  logic [PLANES*WIDTH-1:0] D,
  output logic [PLANES-1:0]       PIX,
  output logic                    LD
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt;
  sr_mode_t         mode;
  logic [WIDTH-1:0] sr [PLANES];

  // Load strobe; gated by _CLR so it stays low while clear is held.
  assign LD = _CLR & PIX_EN & (SYNC | (cnt == CNT_LAST));

  assign mode = sr_mode_decode(PIX_EN, LD, FLIP);

  // Pixel counter: cleared only by a load, never wraps on its own.
  always_ff @(posedge CLK or negedge _CLR) begin
    if (!_CLR) begin
      cnt <= '0;
    end else if (LD) begin
      cnt <= '0;
    end else if (PIX_EN) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // One shift register per plane; output end follows FLIP immediately.
  for (genvar p = 0; p < int'(PLANES); p++) begin : g_plane
    ls299 #(.WIDTH(WIDTH)) u_sr (
      .CLK   (CLK),
      ._CLR  (_CLR),
      .mode  (mode),
      .sin_r (1'b0),
      .sin_l (1'b0),
      .din   (D[p*WIDTH +: WIDTH]),
      .q     (sr[p])
    );
    assign PIX[p] = FLIP ? sr[p][0] : sr[p][WIDTH-1];
  end

endmodule

// File: tb/tb_pixel_shifter.sv
// Testbench for pixel_shifter: directed scenarios plus random traffic,
// checked against a byte-value reference model through a scoreboard queue.
module tb_pixel_shifter;

  localparam int unsigned W   = 8;
  localparam int unsigned P   = 2;
  localparam int unsigned TOP = 1 << (W - 1);
  localparam int unsigned MOD = 1 << W;

  logic           clk = 1'b0;
  logic           clr_n = 1'b0;
  logic           pix_en = 1'b0;
  logic           sync = 1'b0;
  logic           flip = 1'b0;
  logic [P*W-1:0] d = '0;
  logic [P-1:0]   pix;
  logic           ld;

  always #5 clk = ~clk;

  pixel_shifter #(.WIDTH(W), .PLANES(P)) dut (
    .CLK    (clk),
    ._CLR   (clr_n),
    .PIX_EN (pix_en),
    .SYNC   (sync),
    .FLIP   (flip),
    .D      (d),
    .PIX    (pix),
    .LD     (ld)
  );

  typedef struct {
    logic [P-1:0] pix;
    logic         ld;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model: byte value per plane and pixels shown since last load.
  int unsigned mv[P];
  int          mcnt;

  logic [P-1:0] last_pix;
  logic         last_ld;

  int seq0[8] = '{1, 0, 1, 0, 2, 3, 2, 3};
  int seq1[8] = '{3, 2, 3, 2, 0, 1, 0, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [P-1:0] model_pix(input logic f);
    logic [P-1:0] r;
    r = '0;
    for (int p = 0; p < int'(P); p++)
      r[p] = f ? 1'(mv[p] % 2) : 1'(mv[p] / TOP);
    return r;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < int'(P); p++) mv[p] = 0;
    mcnt = 0;
  endtask

  // One clock of stimulus: apply inputs, queue expectation, advance model.
  task automatic step(input logic en, input logic s, input logic f, input logic [P*W-1:0] dv);
    exp_t e;
    logic ld_e;
    @(negedge clk);
    pix_en = en; sync = s; flip = f; d = dv;
    ld_e = en && (s || mcnt == int'(W - 1));
    e.pix = model_pix(f);
    e.ld  = ld_e;
    sbq.push_back(e);
    #3;
    last_pix = pix;
    last_ld  = ld;
    @(posedge clk);
    if (en) begin
      if (ld_e) begin
        for (int p = 0; p < int'(P); p++) mv[p] = 32'(dv[p*W +: W]);
        mcnt = 0;
      end else begin
        for (int p = 0; p < int'(P); p++) mv[p] = f ? mv[p] / 2 : (mv[p] * 2) % MOD;
        mcnt++;
      end
    end
  endtask

  // Monitor: outputs are presented every cycle; compare against queued model.
  always begin : monitor
    exp_t e;
    @(negedge clk);
    #2;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("sb_pix", 32'(pix), 32'(e.pix));
      chk("sb_ld", 32'(ld), 32'(e.ld));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   first;
    logic f;
    model_clear();

    // Clear held from time zero: outputs low even with LD conditions true.
    pix_en = 1'b1; sync = 1'b1;
    #2;
    chk("clr_pix", 32'(pix), 32'd0);
    chk("clr_ld", 32'(ld), 32'd0);
    @(negedge clk);
    clr_n = 1'b1; pix_en = 1'b0; sync = 1'b0;

    // Counter starts at 0: first load on the eighth enabled cycle.
    first = -1;
    for (int i = 0; i < 12 && first < 0; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'($urandom));
      if (last_ld) first = i;
    end
    chk("first_ld_idx", 32'(first), 32'd7);

    // MSB-first sequence.
    step(1'b1, 1'b1, 1'b0, 16'h0FA5);
    chk("sync_ld", 32'(last_ld), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'h0FA5);
      chk("seq_shl_pix", 32'(last_pix), 32'(seq0[i]));
      chk("seq_shl_ld", 32'(last_ld), 32'(i == 7));
    end

    // LSB-first sequence.
    step(1'b1, 1'b1, 1'b1, 16'h0FA5);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 16'($urandom));
      chk("seq_shr_pix", 32'(last_pix), 32'(seq1[i]));
    end

    // Enable every other cycle: each pixel held two cycles.
    step(1'b1, 1'b1, 1'b0, 16'h0FA5);
    for (int i = 0; i < 16; i++) begin
      step(1'(i % 2), 1'b0, 1'b0, 16'($urandom));
      chk("half_rate_pix", 32'(last_pix), 32'(seq0[i/2]));
      chk("half_rate_ld", 32'(last_ld), 32'(i == 15));
    end

    // SYNC mid-byte reloads and discards the remaining pixels.
    step(1'b1, 1'b1, 1'b0, 16'h0FA5);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'($urandom));
    step(1'b1, 1'b1, 1'b0, 16'hFF00);
    chk("resync_ld", 32'(last_ld), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'($urandom));
      chk("resync_pix", 32'(last_pix), 32'd2);
    end

    // FLIP changed mid-byte: output end switches, counter keeps its place.
    step(1'b1, 1'b1, 1'b0, 16'h00F0);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("preflip_pix", 32'(last_pix), 32'd1);
    step(1'b1, 1'b0, 1'b1, 16'h0000);
    chk("postflip_pix", 32'(last_pix), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1, 16'h0000);
      chk("postflip_ld", 32'(last_ld), 32'(i == 4));
    end

    // Asynchronous clear in the middle of a cycle with data loaded.
    step(1'b1, 1'b1, 1'b0, 16'hFFFF);
    #3;
    pix_en = 1'b1; sync = 1'b1; flip = 1'b0;
    chk("preclr_pix", 32'(pix), 32'd3);
    clr_n = 1'b0;
    #1;
    chk("async_clr_pix", 32'(pix), 32'd0);
    chk("async_clr_ld", 32'(ld), 32'd0);
    model_clear();
    @(negedge clk);
    clr_n = 1'b1; pix_en = 1'b0; sync = 1'b0;
    first = -1;
    for (int i = 0; i < 12 && first < 0; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'($urandom));
      if (i == 0) chk("postclr_fill_pix", 32'(last_pix), 32'd0);
      if (last_ld) first = i;
    end
    chk("postclr_ld_idx", 32'(first), 32'd7);

    // Random traffic.
    f = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) f = ~f;
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0), f, 16'($urandom));
    end

    @(negedge clk);
    #4;
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
